// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - AHB-Lite single-word initiator fed from a command FIFO
// Pipelined address/data phases, wait-state and two-cycle ERROR handling, one response per command.
package ahb_lite_pkg;
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } ahb_htrans_enum;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001
   } ahb_hburst_enum;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } ahb_hsize_enum;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } ahb_hresp_enum;
endpackage

module ahb_lite_cmd_master
   import ahb_lite_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic           hclk,
   input  logic           hreset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic           cmd_write,
   input  logic [31:0]    cmd_addr,
   input  logic [31:0]    cmd_wdata,
   output logic           rsp_valid,
   output logic           rsp_write,
   output logic [31:0]    rsp_rdata,
   output logic           rsp_err,
   output logic           busy,
   output logic [31:0]    haddr,
   output logic           hwrite,
   output ahb_htrans_enum htrans,
   output ahb_hburst_enum hburst,
   output ahb_hsize_enum  hsize,
   output logic [3:0]     hprot,
   output logic           hsel,
   output logic [31:0]    hwdata,
   input  logic [31:0]    hrdata,
   input  logic           hready,
   input  ahb_hresp_enum  hresp
);
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_ERR    = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   cmd_t             fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             err_first;
   logic             done;
   cmd_t             ap;
   logic             dp_valid;
   logic             dp_write;
   logic [31:0]      dp_wdata;

   assign fifo_empty = (count == '0);
   assign cmd_ready  = (count != CNT_W'(CMD_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   // First ERROR cycle: the slave has not yet accepted the pending address phase, so it can be withdrawn.
   assign err_first  = dp_valid && !hready && (hresp == HRESP_ERROR);
   assign done       = dp_valid && hready;

   assign haddr  = ap.addr;
   assign hwrite = ap.write;
   assign hwdata = dp_wdata;
   assign hburst = HBURST_SINGLE;
   assign hsize  = HSIZE_WORD;
   assign hprot  = 4'b0011;
   assign hsel   = (htrans == HTRANS_NONSEQ);
   assign busy   = !fifo_empty || (state != ST_IDLE) || dp_valid;

   always_ff @(posedge hclk) begin
      if (hreset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      htrans    = HTRANS_IDLE;
      case (state)
         ST_IDLE: begin
            if (hready && !fifo_empty) begin
               state_nxt = ST_ACTIVE;
               pop       = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (err_first) begin
               state_nxt = ST_ERR;
            end else begin
               htrans = HTRANS_NONSEQ;
               if (hready) begin
                  if (!fifo_empty) pop = 1'b1;
                  else             state_nxt = ST_IDLE;
               end
            end
         end
         ST_ERR: begin
            if (hready) state_nxt = ST_ACTIVE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (push) fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr & 32'hFFFF_FFFC, wdata: cmd_wdata};
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ap        <= '0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_wdata  <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            ap     <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (hready) begin
            dp_valid <= (state == ST_ACTIVE);
            if (state == ST_ACTIVE) begin
               dp_write <= ap.write;
               dp_wdata <= ap.wdata;
            end
         end
         rsp_valid <= done;
         rsp_write <= done && dp_write;
         rsp_err   <= done && (hresp == HRESP_ERROR);
         rsp_rdata <= (done && !dp_write && (hresp == HRESP_OKAY)) ? hrdata : '0;
      end
   end
endmodule
